// File: rtl/reg_file_sb.sv
// Dual-read, dual-write register file with optional write-to-read bypass,
// optional hard-wired zero register and a per-register load-pending scoreboard.
module reg_file_sb #(
    parameter int W       = 8,
    parameter int D       = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [D-1:0] RaddrA,
    input  logic [D-1:0] RaddrB,
    output logic [W-1:0] DataOutA,
    output logic [W-1:0] DataOutB,
    output logic         ReadyA,
    output logic         ReadyB,
    input  logic         WriteEnA,
    input  logic [D-1:0] WaddrA,
    input  logic [W-1:0] DataInA,
    input  logic         WriteEnB,
    input  logic [D-1:0] WaddrB,
    input  logic [W-1:0] DataInB,
    input  logic         PendSet,
    input  logic [D-1:0] PendAddr,
    output logic         AnyPending,
    output logic         PendConflict
);

    localparam int N = 2 ** D;

    logic [N-1:0][W-1:0] regs_r;
    logic [N-1:0]        pend_r;
    logic [N-1:0]        pend_nxt_s;
    logic                conflict_r;
    logic                conflict_nxt_s;
    logic                wa_en_s;
    logic                wb_en_s;
    logic                set_s;
    logic [W-1:0]        data_a_s;
    logic [W-1:0]        data_b_s;
    logic                ready_a_s;
    logic                ready_b_s;

    // Read mux shared by both ports; port A bypass has priority, matching the write rule.
    function automatic logic [W-1:0] read_mux(
        input logic [D-1:0]          ra,
        input logic [N-1:0][W-1:0]   regs,
        input logic                  wea,
        input logic [D-1:0]          waa,
        input logic [W-1:0]          dia,
        input logic                  web,
        input logic [D-1:0]          wab,
        input logic [W-1:0]          dib
    );
        logic [W-1:0] res;
        if ((ZERO_R0 != 0) && (ra == {D{1'b0}})) begin
            res = {W{1'b0}};
        end else if ((BYPASS != 0) && wea && (waa == ra)) begin
            res = dia;
        end else if ((BYPASS != 0) && web && (wab == ra)) begin
            res = dib;
        end else begin
            res = regs[ra];
        end
        return res;
    endfunction

    // Qualified write/set strobes after zero-register masking and A-over-B arbitration.
    always_comb begin
        wa_en_s = WriteEnA && !((ZERO_R0 != 0) && (WaddrA == {D{1'b0}}));
        wb_en_s = WriteEnB && !((ZERO_R0 != 0) && (WaddrB == {D{1'b0}}))
                  && !(WriteEnA && (WaddrA == WaddrB));
        set_s   = PendSet && !((ZERO_R0 != 0) && (PendAddr == {D{1'b0}}));
    end

    // Register array storage.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            regs_r <= '0;
        end else begin
            if (wa_en_s) begin
                regs_r[WaddrA] <= DataInA;
            end
            if (wb_en_s) begin
                regs_r[WaddrB] <= DataInB;
            end
        end
    end

    // Scoreboard next state: set beats clear, port A never touches pending.
    always_comb begin
        pend_nxt_s = pend_r;
        for (int i = 0; i < N; i++) begin
            if (set_s && (PendAddr == D'(i))) begin
                pend_nxt_s[i] = 1'b1;
            end else if (WriteEnB && (WaddrB == D'(i))) begin
                pend_nxt_s[i] = 1'b0;
            end else begin
                pend_nxt_s[i] = pend_r[i];
            end
        end
        conflict_nxt_s = set_s && pend_r[PendAddr] && !(WriteEnB && (WaddrB == PendAddr));
    end

    // Scoreboard and conflict flag registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pend_r     <= {N{1'b0}};
            conflict_r <= 1'b0;
        end else begin
            pend_r     <= pend_nxt_s;
            conflict_r <= conflict_nxt_s;
        end
    end

    // Combinational read data and operand readiness; a landing load counts as ready when bypassing.
    always_comb begin
        data_a_s = read_mux(RaddrA, regs_r, WriteEnA, WaddrA, DataInA, WriteEnB, WaddrB, DataInB);
        data_b_s = read_mux(RaddrB, regs_r, WriteEnA, WaddrA, DataInA, WriteEnB, WaddrB, DataInB);
        if ((BYPASS != 0) && WriteEnB && (WaddrB == RaddrA) && !(set_s && (PendAddr == RaddrA))) begin
            ready_a_s = 1'b1;
        end else begin
            ready_a_s = ~pend_r[RaddrA];
        end
        if ((BYPASS != 0) && WriteEnB && (WaddrB == RaddrB) && !(set_s && (PendAddr == RaddrB))) begin
            ready_b_s = 1'b1;
        end else begin
            ready_b_s = ~pend_r[RaddrB];
        end
    end

    assign DataOutA     = data_a_s;
    assign DataOutB     = data_b_s;
    assign ReadyA       = ready_a_s;
    assign ReadyB       = ready_b_s;
    assign AnyPending   = |pend_r;
    assign PendConflict = conflict_r;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default build, a no-bypass build and a zero-register build
// share one stimulus stream.
module tb_reg_file_sb;

    localparam int W = 8;
    localparam int D = 3;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [D-1:0] RaddrA, RaddrB, WaddrA, WaddrB, PendAddr;
    logic [W-1:0] DataInA, DataInB;
    logic         WriteEnA, WriteEnB, PendSet;

    logic [W-1:0] d_outa, d_outb, n_outa, n_outb, z_outa, z_outb;
    logic         d_rdya, d_rdyb, n_rdya, n_rdyb, z_rdya, z_rdyb;
    logic         d_any, n_any, z_any, d_conf, n_conf, z_conf;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    reg_file_sb #(.W(W), .D(D), .BYPASS(1), .ZERO_R0(0)) u_dut (
        .Clk(Clk), .Reset(Reset), .RaddrA(RaddrA), .RaddrB(RaddrB),
        .DataOutA(d_outa), .DataOutB(d_outb), .ReadyA(d_rdya), .ReadyB(d_rdyb),
        .WriteEnA(WriteEnA), .WaddrA(WaddrA), .DataInA(DataInA),
        .WriteEnB(WriteEnB), .WaddrB(WaddrB), .DataInB(DataInB),
        .PendSet(PendSet), .PendAddr(PendAddr), .AnyPending(d_any), .PendConflict(d_conf));

    reg_file_sb #(.W(W), .D(D), .BYPASS(0), .ZERO_R0(0)) u_nb (
        .Clk(Clk), .Reset(Reset), .RaddrA(RaddrA), .RaddrB(RaddrB),
        .DataOutA(n_outa), .DataOutB(n_outb), .ReadyA(n_rdya), .ReadyB(n_rdyb),
        .WriteEnA(WriteEnA), .WaddrA(WaddrA), .DataInA(DataInA),
        .WriteEnB(WriteEnB), .WaddrB(WaddrB), .DataInB(DataInB),
        .PendSet(PendSet), .PendAddr(PendAddr), .AnyPending(n_any), .PendConflict(n_conf));

    reg_file_sb #(.W(W), .D(D), .BYPASS(1), .ZERO_R0(1)) u_z (
        .Clk(Clk), .Reset(Reset), .RaddrA(RaddrA), .RaddrB(RaddrB),
        .DataOutA(z_outa), .DataOutB(z_outb), .ReadyA(z_rdya), .ReadyB(z_rdyb),
        .WriteEnA(WriteEnA), .WaddrA(WaddrA), .DataInA(DataInA),
        .WriteEnB(WriteEnB), .WaddrB(WaddrB), .DataInB(DataInB),
        .PendSet(PendSet), .PendAddr(PendAddr), .AnyPending(z_any), .PendConflict(z_conf));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        WriteEnA = 1'b0; WriteEnB = 1'b0; PendSet = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1;
        RaddrA = 3'd0; RaddrB = 3'd0; WaddrA = 3'd0; WaddrB = 3'd0; PendAddr = 3'd0;
        DataInA = 8'h00; DataInB = 8'h00;
        idle();
        tick(); tick();
        for (int i = 0; i < 8; i++) begin
            RaddrA = 3'(i); RaddrB = 3'(7 - i);
            #1;
            check($sformatf("rst_outa_%0d", i), 32'(d_outa), 32'h00);
            check($sformatf("rst_outb_%0d", i), 32'(d_outb), 32'h00);
            check($sformatf("rst_rdya_%0d", i), 32'(d_rdya), 32'h1);
            check($sformatf("rst_rdyb_%0d", i), 32'(d_rdyb), 32'h1);
        end
        check("rst_any", 32'(d_any), 32'h0);
        check("rst_conf", 32'(d_conf), 32'h0);
        Reset = 1'b0;
        tick();

        // Port A write, read back next cycle
        WriteEnA = 1'b1; WaddrA = 3'd3; DataInA = 8'hA5; RaddrA = 3'd2;
        tick();
        idle(); RaddrA = 3'd3; #1;
        check("wrA_r3", 32'(d_outa), 32'hA5);
        check("wrA_r3_nb", 32'(n_outa), 32'hA5);

        // Same-cycle bypass vs stored value
        WriteEnA = 1'b1; WaddrA = 3'd2; DataInA = 8'h3C; RaddrA = 3'd2; #1;
        check("byp_r2", 32'(d_outa), 32'h3C);
        check("nobyp_r2_old", 32'(n_outa), 32'h00);
        tick();
        idle(); #1;
        check("nobyp_r2_new", 32'(n_outa), 32'h3C);
        check("byp_r2_stored", 32'(d_outa), 32'h3C);

        // Dual write collision on r5: A wins in storage and bypass
        WriteEnA = 1'b1; WaddrA = 3'd5; DataInA = 8'h11;
        WriteEnB = 1'b1; WaddrB = 3'd5; DataInB = 8'h22;
        RaddrA = 3'd5; RaddrB = 3'd5; #1;
        check("coll_byp_a", 32'(d_outa), 32'h11);
        check("coll_byp_b", 32'(d_outb), 32'h11);
        tick();
        idle(); #1;
        check("coll_r5", 32'(d_outa), 32'h11);
        check("coll_r5_nb", 32'(n_outb), 32'h11);

        // Pending set on r4, then load landing clears it
        PendSet = 1'b1; PendAddr = 3'd4; RaddrA = 3'd4; #1;
        check("pend_pre_rdy", 32'(d_rdya), 32'h1);
        check("pend_pre_any", 32'(d_any), 32'h0);
        tick();
        idle(); #1;
        check("pend_r4_rdy", 32'(d_rdya), 32'h0);
        check("pend_r4_any", 32'(d_any), 32'h1);
        check("pend_r4_conf", 32'(d_conf), 32'h0);
        WriteEnB = 1'b1; WaddrB = 3'd4; DataInB = 8'h7E; #1;
        check("land_rdy_byp", 32'(d_rdya), 32'h1);
        check("land_data_byp", 32'(d_outa), 32'h7E);
        check("land_rdy_nb", 32'(n_rdya), 32'h0);
        check("land_any_same", 32'(d_any), 32'h1);
        tick();
        idle(); #1;
        check("land_any_after", 32'(d_any), 32'h0);
        check("land_rdy_after", 32'(d_rdya), 32'h1);
        check("land_rdy_nb_after", 32'(n_rdya), 32'h1);
        check("land_r4_stored", 32'(n_outa), 32'h7E);

        // Set and clear r6 in one cycle: set wins, no conflict
        PendSet = 1'b1; PendAddr = 3'd6; WriteEnB = 1'b1; WaddrB = 3'd6; DataInB = 8'h99;
        RaddrA = 3'd6;
        tick();
        idle(); #1;
        check("setclr_rdy", 32'(d_rdya), 32'h0);
        check("setclr_any", 32'(d_any), 32'h1);
        check("setclr_conf", 32'(d_conf), 32'h0);
        PendSet = 1'b1; PendAddr = 3'd6;
        tick();
        idle(); #1;
        check("conf_pulse", 32'(d_conf), 32'h1);
        tick();
        check("conf_one_cycle", 32'(d_conf), 32'h0);
        // Re-set while pending but cleared same cycle: no conflict, stays pending
        PendSet = 1'b1; PendAddr = 3'd6; WriteEnB = 1'b1; WaddrB = 3'd6; DataInB = 8'h44; #1;
        check("reset_clr_rdy_same", 32'(d_rdya), 32'h0);
        tick();
        idle(); #1;
        check("reset_clr_conf", 32'(d_conf), 32'h0);
        check("reset_clr_rdy", 32'(d_rdya), 32'h0);
        WriteEnB = 1'b1; WaddrB = 3'd6; DataInB = 8'h45;
        tick();
        idle(); #1;
        check("r6_cleared_any", 32'(d_any), 32'h0);
        check("r6_data", 32'(d_outa), 32'h45);

        // Zero register build ignores writes and pending-sets on r0
        WriteEnA = 1'b1; WaddrA = 3'd0; DataInA = 8'hFF; PendSet = 1'b1; PendAddr = 3'd0;
        RaddrA = 3'd0; #1;
        check("z_byp_r0", 32'(z_outa), 32'h00);
        check("nz_byp_r0", 32'(d_outa), 32'hFF);
        tick();
        idle(); #1;
        check("z_r0_data", 32'(z_outa), 32'h00);
        check("z_r0_rdy", 32'(z_rdya), 32'h1);
        check("z_r0_any", 32'(z_any), 32'h0);
        check("nz_r0_data", 32'(d_outa), 32'hFF);
        check("nz_r0_rdy", 32'(d_rdya), 32'h0);

        // Async reset mid-sequence with r1 pending and holding 8'h55
        WriteEnA = 1'b1; WaddrA = 3'd1; DataInA = 8'h55; PendSet = 1'b1; PendAddr = 3'd1;
        tick();
        idle(); RaddrA = 3'd1; #1;
        check("pre_rst_r1", 32'(d_outa), 32'h55);
        check("pre_rst_rdy", 32'(d_rdya), 32'h0);
        Reset = 1'b1; #1;
        check("async_rst_r1", 32'(d_outa), 32'h00);
        check("async_rst_rdy", 32'(d_rdya), 32'h1);
        check("async_rst_any", 32'(d_any), 32'h0);
        WriteEnA = 1'b1; WaddrA = 3'd1; DataInA = 8'h66;
        tick();
        Reset = 1'b0; idle(); #1;
        check("rst_drop_write", 32'(d_outa), 32'h00);
        check("rst_drop_write_nb", 32'(n_outa), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
